l1_d_controller_nway: RTL and testbench
=======================================

Name: l1_d_controller_nway

Overview:
Parametrised N-way set-associative successor to the direct-mapped L1 data-cache controller. It sits between the core load/store port and the L2 interface. It holds tag, valid, dirty and LRU state per set, resolves hits, and sequences write-back and allocate transactions to L2. It also walks the whole cache on flush. The data array is external and is steered by refill, update and way_sel.

Parameters:
TAG_WIDTH, 52, tag bits (address[63:12])
INDEX_WIDTH, 6, set index bits (address[11:6]); SETS = 2**INDEX_WIDTH
WAYS, 4, associativity, power of two, minimum 2; WB = $clog2(WAYS)

Ports:
clk  in  1  clock
nrst  in  1  reset, synchronous, active-low
tag  in  TAG_WIDTH  request tag
index  in  INDEX_WIDTH  request set
read_C_L1  in  1  core load request (level, held until stall low)
write_C_L1  in  1  core store request (level)
flush  in  1  flush request (level)
stall  out  1  core must hold request
refill  out  1  one-cycle pulse: write L2 line into way_sel of l2_index
update  out  1  store hit: write core data into way_sel
way_sel  out  WB  selected way for data array
read_L1_L2  out  1  allocate request to L2
write_L1_L2  out  1  write-back request to L2
ready_L2_L1  in  1  L2 completion pulse
l2_tag  out  TAG_WIDTH  line tag of current L2 transaction
l2_index  out  INDEX_WIDTH  line set of current L2 transaction
flush_done  out  1  one-cycle pulse when flush finished

Behaviour:
- Reset: nrst=0 at a clk edge clears all valid and dirty bits and sets age[s][w]=w for every set. State goes to IDLE. All outputs are 0, l2_tag and l2_index are 0. A reset during any state aborts it in that cycle and no L2 request remains asserted.
- States: IDLE, WRITEBACK, ALLOCATE, REFILL, FLUSH_SCAN, FLUSH_WB, FLUSH_DONE.
- IDLE lookup is combinational. hit = valid && tag match in any way, and way_sel = the hit way.
- Read hit: stall=0 in the same cycle, zero-cycle latency.
- Write hit: stall=0, update=1 for that cycle, dirty set at the edge.
- Both read and write asserted: treat as write.
- Any hit updates LRU at the edge: ways with age < age[hit] increment, and age[hit] becomes 0.
- Miss with a request: stall=1 in the same cycle. Victim = lowest-numbered invalid way, otherwise the way with age WAYS-1. The victim is latched.
  - Victim dirty → WRITEBACK: write_L1_L2=1, l2_tag/l2_index = victim line, held until ready_L2_L1. At ready, clear dirty and go to ALLOCATE.
  - Victim clean → ALLOCATE directly: read_L1_L2=1, l2_tag/l2_index = request line, held until ready_L2_L1, then REFILL.
- REFILL lasts one cycle: refill=1, way_sel=victim, stall=1. Tag is written, valid=1, dirty=0, and LRU is updated as for an access. Then IDLE, where the held request hits: read completes with stall=0, write does update=1.
- stall=1 in every non-IDLE state. A clean-miss read costs (L2 cycles + 2) stall cycles.
- flush sampled in IDLE takes priority over a concurrent request. Outside IDLE it is ignored until the controller returns to IDLE.
- FLUSH_SCAN walks set/way counters from 0 upward, one line per cycle. A dirty line → FLUSH_WB (write_L1_L2 with that line's tag/index, wait for ready, clear dirty), then resume scanning. After the last set and last way, all valid bits clear → FLUSH_DONE, which pulses flush_done for one cycle → IDLE.
- flush still high on return to IDLE does not restart a flush. flush must drop before the next flush is accepted (edge-qualified).
- ready_L2_L1 outside WRITEBACK, ALLOCATE and FLUSH_WB is ignored.
- LRU ages always remain a permutation of 0..WAYS-1 per set.

Decomposition:
- Package l1_cache_pkg: state enum, TAG_WIDTH/INDEX_WIDTH defaults, address-split constants.
- Sub-module l1_lru_nway: per-set age arrays, with access-update and victim-select ports.

Test Plan:
- Reset, then read tag=0x1, index=5: stall=1, read_L1_L2=1, l2_index=5. After ready, refill=1 with way_sel=0, then stall=0.
- WAYS=4: fill ways 0-3 of set 5 with tags 1-4, read tag 1, then miss tag 5: victim = way 1 (tag 2), no write-back.
- Write-hit tag 1 (update=1, dirty set), then evict way 0: write_L1_L2=1 with l2_tag=1 before read_L1_L2. Ready held off 5 cycles keeps stall=1 throughout.
- Read and write asserted together on a hit: update=1, treated as write.
- Two dirty lines in sets 0 and 63, then assert flush: exactly two write_L1_L2 transactions in set order. flush_done pulses once, and a subsequent read of either line misses.
- nrst=0 during ALLOCATE: next cycle read_L1_L2=0 and all lines are invalid. The refill is never issued.

Source files
------------

// File: rtl/l1_cache_pkg.sv
// Shared types and geometry for the L1 data-cache controller.
// Address split: [63:12] tag, [11:6] set index, [5:0] line offset.
package l1_cache_pkg;
  localparam int ADDR_WIDTH     = 64;
  localparam int INDEX_LSB      = 6;
  localparam int TAG_LSB        = 12;
  localparam int L1_INDEX_WIDTH = TAG_LSB - INDEX_LSB;
  localparam int L1_TAG_WIDTH   = ADDR_WIDTH - TAG_LSB;
  localparam int L1_WAYS        = 4;

  typedef enum logic [2:0] {
    IDLE,
    WRITEBACK,
    ALLOCATE,
    REFILL,
    FLUSH_SCAN,
    FLUSH_WB,
    FLUSH_DONE
  } state_e;
endpackage

// File: rtl/l1_d_controller_nway_if.sv
// Core-side and L2-side signals of the L1 controller.
// master = core/L2 environment, slave = controller.
interface l1_d_controller_nway_if #(
  parameter int TAG_WIDTH   = l1_cache_pkg::L1_TAG_WIDTH,
  parameter int INDEX_WIDTH = l1_cache_pkg::L1_INDEX_WIDTH,
  parameter int WAYS        = l1_cache_pkg::L1_WAYS
);
  localparam int WB = $clog2(WAYS);

  logic [TAG_WIDTH-1:0]   tag;
  logic [INDEX_WIDTH-1:0] index;
  logic                   read_C_L1;
  logic                   write_C_L1;
  logic                   flush;
  logic                   stall;
  logic                   refill;
  logic                   update;
  logic [WB-1:0]          way_sel;
  logic                   read_L1_L2;
  logic                   write_L1_L2;
  logic                   ready_L2_L1;
  logic [TAG_WIDTH-1:0]   l2_tag;
  logic [INDEX_WIDTH-1:0] l2_index;
  logic                   flush_done;

  modport master (
    output tag, index, read_C_L1, write_C_L1, flush, ready_L2_L1,
    input  stall, refill, update, way_sel, read_L1_L2, write_L1_L2,
           l2_tag, l2_index, flush_done
  );

  modport slave (
    input  tag, index, read_C_L1, write_C_L1, flush, ready_L2_L1,
    output stall, refill, update, way_sel, read_L1_L2, write_L1_L2,
           l2_tag, l2_index, flush_done
  );
endinterface

// File: rtl/l1_lru_nway.sv
// Per-set age-based LRU: age 0 = most recent, WAYS-1 = next victim.
// Access updates at the clock edge; victim lookup is combinational.
module l1_lru_nway #(
  parameter int INDEX_WIDTH = 6,
  parameter int WAYS        = 4,
  parameter int WB          = $clog2(WAYS)
) (
  input  logic                   clk,
  input  logic                   nrst,
  input  logic                   acc_vld,
  input  logic [INDEX_WIDTH-1:0] acc_set,
  input  logic [WB-1:0]          acc_way,
  input  logic [INDEX_WIDTH-1:0] sel_set,
  output logic [WB-1:0]          victim_way
);
  localparam int SETS = 1 << INDEX_WIDTH;
  localparam logic [WB-1:0] AGE_MAX = WB'(WAYS - 1);

  logic [WB-1:0] age_q [SETS][WAYS];
  logic [WB-1:0] age_d [SETS][WAYS];

  // Younger-than-accessed ways age by one; others keep their age, so the set stays a permutation.
  always_comb begin
    age_d = age_q;
    if (acc_vld) begin
      for (int w = 0; w < WAYS; w++) begin
        if (age_q[acc_set][w] < age_q[acc_set][acc_way]) begin
          age_d[acc_set][w] = age_q[acc_set][w] + 1'b1;
        end
      end
      age_d[acc_set][acc_way] = '0;
    end
  end

  always_comb begin
    victim_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (age_q[sel_set][w] == AGE_MAX) victim_way = WB'(w);
    end
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      for (int s = 0; s < SETS; s++) begin
        for (int w = 0; w < WAYS; w++) age_q[s][w] <= WB'(w);
      end
    end else begin
      age_q <= age_d;
    end
  end
endmodule

// File: rtl/l1_d_controller_nway.sv
// N-way L1 data-cache controller: tag/valid/dirty state, hit resolution, L2 write-back/allocate, flush walk.
// Hits resolve in the same cycle; misses stall the core until the refill cycle, L2 requests hold until ready_L2_L1.
module l1_d_controller_nway
  import l1_cache_pkg::*;
#(
  parameter int TAG_WIDTH   = L1_TAG_WIDTH,
  parameter int INDEX_WIDTH = L1_INDEX_WIDTH,
  parameter int WAYS        = L1_WAYS
) (
  input logic                  clk,
  input logic                  nrst,
  l1_d_controller_nway_if.slave bus
);
  localparam int SETS = 1 << INDEX_WIDTH;
  localparam int WB   = $clog2(WAYS);

  state_e                 state_q, state_d;
  logic [TAG_WIDTH-1:0]   tag_q [SETS][WAYS];
  logic [TAG_WIDTH-1:0]   tag_d [SETS][WAYS];
  logic [WAYS-1:0]        valid_q [SETS];
  logic [WAYS-1:0]        valid_d [SETS];
  logic [WAYS-1:0]        dirty_q [SETS];
  logic [WAYS-1:0]        dirty_d [SETS];
  logic [WB-1:0]          victim_q, victim_d;
  logic [INDEX_WIDTH-1:0] fset_q, fset_d;
  logic [WB-1:0]          fway_q, fway_d;
  logic                   flush_blk_q, flush_blk_d;
  logic [TAG_WIDTH-1:0]   l2_tag_q, l2_tag_d;
  logic [INDEX_WIDTH-1:0] l2_index_q, l2_index_d;

  logic                   hit, inv_found, req;
  logic [WB-1:0]          hit_way, inv_way, victim_sel, lru_victim, lru_way;
  logic [INDEX_WIDTH-1:0] lru_set;
  logic                   lru_vld;
  logic                   stall_o, update_o, refill_o, rd_l2, wr_l2, done_o;
  logic [WB-1:0]          way_sel_o;

  l1_lru_nway #(.INDEX_WIDTH(INDEX_WIDTH), .WAYS(WAYS), .WB(WB)) u_lru (
    .clk        (clk),
    .nrst       (nrst),
    .acc_vld    (lru_vld),
    .acc_set    (lru_set),
    .acc_way    (lru_way),
    .sel_set    (bus.index),
    .victim_way (lru_victim)
  );

  assign req = bus.read_C_L1 | bus.write_C_L1;

  always_comb begin
    hit       = 1'b0;
    hit_way   = '0;
    inv_found = 1'b0;
    inv_way   = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (!hit && valid_q[bus.index][w] && tag_q[bus.index][w] == bus.tag) begin
        hit     = 1'b1;
        hit_way = WB'(w);
      end
      if (!inv_found && !valid_q[bus.index][w]) begin
        inv_found = 1'b1;
        inv_way   = WB'(w);
      end
    end
    victim_sel = inv_found ? inv_way : lru_victim;
  end

  always_comb begin
    state_d     = state_q;
    tag_d       = tag_q;
    valid_d     = valid_q;
    dirty_d     = dirty_q;
    victim_d    = victim_q;
    fset_d      = fset_q;
    fway_d      = fway_q;
    flush_blk_d = flush_blk_q & bus.flush;
    l2_tag_d    = l2_tag_q;
    l2_index_d  = l2_index_q;
    stall_o     = 1'b1;
    update_o    = 1'b0;
    refill_o    = 1'b0;
    rd_l2       = 1'b0;
    wr_l2       = 1'b0;
    done_o      = 1'b0;
    way_sel_o   = victim_q;
    lru_vld     = 1'b0;
    lru_set     = bus.index;
    lru_way     = hit_way;
    case (state_q)
      IDLE: begin
        stall_o   = 1'b0;
        way_sel_o = hit ? hit_way : '0;
        // flush_blk keeps a flush that is still held high from restarting the walk.
        if (bus.flush && !flush_blk_q) begin
          stall_o     = 1'b1;
          flush_blk_d = 1'b1;
          fset_d      = '0;
          fway_d      = '0;
          state_d     = FLUSH_SCAN;
        end else if (req && hit) begin
          lru_vld = 1'b1;
          if (bus.write_C_L1) begin
            update_o                  = 1'b1;
            dirty_d[bus.index][hit_way] = 1'b1;
          end
        end else if (req) begin
          stall_o    = 1'b1;
          victim_d   = victim_sel;
          l2_index_d = bus.index;
          if (valid_q[bus.index][victim_sel] && dirty_q[bus.index][victim_sel]) begin
            l2_tag_d = tag_q[bus.index][victim_sel];
            state_d  = WRITEBACK;
          end else begin
            l2_tag_d = bus.tag;
            state_d  = ALLOCATE;
          end
        end
      end
      WRITEBACK: begin
        wr_l2 = 1'b1;
        if (bus.ready_L2_L1) begin
          dirty_d[l2_index_q][victim_q] = 1'b0;
          l2_tag_d   = bus.tag;
          l2_index_d = bus.index;
          state_d    = ALLOCATE;
        end
      end
      ALLOCATE: begin
        rd_l2 = 1'b1;
        if (bus.ready_L2_L1) state_d = REFILL;
      end
      REFILL: begin
        refill_o                       = 1'b1;
        tag_d[l2_index_q][victim_q]    = l2_tag_q;
        valid_d[l2_index_q][victim_q]  = 1'b1;
        dirty_d[l2_index_q][victim_q]  = 1'b0;
        lru_vld    = 1'b1;
        lru_set    = l2_index_q;
        lru_way    = victim_q;
        l2_tag_d   = '0;
        l2_index_d = '0;
        state_d    = IDLE;
      end
      FLUSH_SCAN: begin
        way_sel_o = fway_q;
        if (valid_q[fset_q][fway_q] && dirty_q[fset_q][fway_q]) begin
          l2_tag_d   = tag_q[fset_q][fway_q];
          l2_index_d = fset_q;
          state_d    = FLUSH_WB;
        end else if (fset_q == '1 && fway_q == '1) begin
          valid_d = '{default: '0};
          state_d = FLUSH_DONE;
        end else if (fway_q == '1) begin
          fway_d = '0;
          fset_d = fset_q + 1'b1;
        end else begin
          fway_d = fway_q + 1'b1;
        end
      end
      FLUSH_WB: begin
        way_sel_o = fway_q;
        wr_l2     = 1'b1;
        // Dropping back to scan re-visits this line, now clean, and advances from there.
        if (bus.ready_L2_L1) begin
          dirty_d[fset_q][fway_q] = 1'b0;
          l2_tag_d   = '0;
          l2_index_d = '0;
          state_d    = FLUSH_SCAN;
        end
      end
      FLUSH_DONE: begin
        done_o  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q     <= IDLE;
      valid_q     <= '{default: '0};
      dirty_q     <= '{default: '0};
      victim_q    <= '0;
      fset_q      <= '0;
      fway_q      <= '0;
      flush_blk_q <= 1'b0;
      l2_tag_q    <= '0;
      l2_index_q  <= '0;
    end else begin
      state_q     <= state_d;
      valid_q     <= valid_d;
      dirty_q     <= dirty_d;
      victim_q    <= victim_d;
      fset_q      <= fset_d;
      fway_q      <= fway_d;
      flush_blk_q <= flush_blk_d;
      l2_tag_q    <= l2_tag_d;
      l2_index_q  <= l2_index_d;
    end
  end

  // Tags are qualified by valid, so they need no reset.
  always_ff @(posedge clk) begin
    tag_q <= tag_d;
  end

  assign bus.stall       = stall_o;
  assign bus.update      = update_o;
  assign bus.refill      = refill_o;
  assign bus.read_L1_L2  = rd_l2;
  assign bus.write_L1_L2 = wr_l2;
  assign bus.flush_done  = done_o;
  assign bus.way_sel     = way_sel_o;
  assign bus.l2_tag      = l2_tag_q;
  assign bus.l2_index    = l2_index_q;
endmodule

// File: tb/tb_l1_d_controller_nway.sv
// Directed bench for l1_d_controller_nway: misses, LRU victim choice, write-back ordering, flush, reset abort.
module tb_l1_d_controller_nway;
  logic clk = 1'b0;
  logic nrst = 1'b0;
  always #5 clk = ~clk;

  l1_d_controller_nway_if #(.TAG_WIDTH(52), .INDEX_WIDTH(6), .WAYS(4)) bus ();
  l1_d_controller_nway #(.TAG_WIDTH(52), .INDEX_WIDTH(6), .WAYS(4)) dut (
    .clk  (clk),
    .nrst (nrst),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;
  int          ev_kind [$];
  logic [51:0] ev_tag  [$];
  logic [5:0]  ev_idx  [$];

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  task automatic clear_ev();
    ev_kind.delete();
    ev_tag.delete();
    ev_idx.delete();
  endtask

  // Entered at a falling edge; plays L2 with `hold` wait cycles per transaction until the core is released.
  task automatic run_req(input logic rd, input logic wr, input logic [51:0] tg, input logic [5:0] ix,
                         input int hold, output int stall_cyc, output int rf_way,
                         output logic upd, output logic [1:0] hway);
    int  cnt;
    bit  done;
    cnt = 0; stall_cyc = 0; rf_way = -1; upd = 1'b0; hway = 2'd0; done = 1'b0;
    bus.read_C_L1 = rd; bus.write_C_L1 = wr; bus.tag = tg; bus.index = ix;
    for (int c = 0; c < 200 && !done; c++) begin
      bus.ready_L2_L1 = 1'b0;
      #1;
      if (!bus.stall) begin
        done = 1'b1;
        upd  = bus.update;
        hway = bus.way_sel;
      end else begin
        stall_cyc++;
        if (bus.refill) rf_way = int'(bus.way_sel);
        if (bus.read_L1_L2 || bus.write_L1_L2) begin
          if (cnt == hold) begin
            bus.ready_L2_L1 = 1'b1;
            cnt = 0;
            ev_kind.push_back(bus.write_L1_L2 ? 1 : 2);
            ev_tag.push_back(bus.l2_tag);
            ev_idx.push_back(bus.l2_index);
          end else begin
            cnt++;
          end
        end
        @(negedge clk);
      end
    end
    chk("req_completes", 64'(done), 64'd1);
    @(negedge clk);
    bus.read_C_L1 = 1'b0; bus.write_C_L1 = 1'b0; bus.ready_L2_L1 = 1'b0;
  endtask

  int         sc, rw, nd;
  logic       up;
  logic [1:0] hw;

  initial begin
    bus.tag = '0; bus.index = '0; bus.read_C_L1 = 1'b0; bus.write_C_L1 = 1'b0;
    bus.flush = 1'b0; bus.ready_L2_L1 = 1'b0;
    nrst = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_stall", 64'(bus.stall), 64'd0);
    chk("rst_rd_l2", 64'(bus.read_L1_L2), 64'd0);
    chk("rst_wr_l2", 64'(bus.write_L1_L2), 64'd0);
    chk("rst_refill", 64'(bus.refill), 64'd0);
    chk("rst_flush_done", 64'(bus.flush_done), 64'd0);
    chk("rst_l2_tag", 64'(bus.l2_tag), 64'd0);
    chk("rst_l2_index", 64'(bus.l2_index), 64'd0);
    @(negedge clk);
    nrst = 1'b1;

    // First miss, stepped by hand
    @(negedge clk);
    bus.read_C_L1 = 1'b1; bus.tag = 52'h1; bus.index = 6'd5;
    #1;
    chk("miss_stall", 64'(bus.stall), 64'd1);
    chk("miss_no_rd_yet", 64'(bus.read_L1_L2), 64'd0);
    @(negedge clk); #1;
    chk("alloc_rd_l2", 64'(bus.read_L1_L2), 64'd1);
    chk("alloc_l2_index", 64'(bus.l2_index), 64'd5);
    chk("alloc_l2_tag", 64'(bus.l2_tag), 64'd1);
    bus.ready_L2_L1 = 1'b1;
    @(negedge clk);
    bus.ready_L2_L1 = 1'b0;
    #1;
    chk("refill_pulse", 64'(bus.refill), 64'd1);
    chk("refill_way", 64'(bus.way_sel), 64'd0);
    chk("refill_stall", 64'(bus.stall), 64'd1);
    @(negedge clk); #1;
    chk("hit_after_refill_stall", 64'(bus.stall), 64'd0);
    chk("hit_after_refill_refill", 64'(bus.refill), 64'd0);
    @(negedge clk);
    bus.read_C_L1 = 1'b0;

    // Fill set 5, touch tag 1, then tag 5 must evict way 1
    run_req(1'b1, 1'b0, 52'h2, 6'd5, 0, sc, rw, up, hw);
    chk("fill2_way", 64'(rw), 64'd1);
    run_req(1'b1, 1'b0, 52'h3, 6'd5, 0, sc, rw, up, hw);
    chk("fill3_way", 64'(rw), 64'd2);
    run_req(1'b1, 1'b0, 52'h4, 6'd5, 0, sc, rw, up, hw);
    chk("fill4_way", 64'(rw), 64'd3);
    run_req(1'b1, 1'b0, 52'h1, 6'd5, 0, sc, rw, up, hw);
    chk("read_hit_stall_cycles", 64'(sc), 64'd0);
    chk("read_hit_way", 64'(hw), 64'd0);
    chk("read_hit_no_update", 64'(up), 64'd0);
    clear_ev();
    run_req(1'b1, 1'b0, 52'h5, 6'd5, 0, sc, rw, up, hw);
    chk("lru_victim_way", 64'(rw), 64'd1);
    chk("clean_miss_stall_cycles", 64'(sc), 64'd3);
    chk("clean_miss_one_txn", 64'(ev_kind.size()), 64'd1);

    // Dirty tag 1 in way 0, age it to LRU, then evict with L2 held off 5 cycles
    run_req(1'b0, 1'b1, 52'h1, 6'd5, 0, sc, rw, up, hw);
    chk("write_hit_update", 64'(up), 64'd1);
    chk("write_hit_way", 64'(hw), 64'd0);
    chk("write_hit_stall_cycles", 64'(sc), 64'd0);
    run_req(1'b1, 1'b0, 52'h3, 6'd5, 0, sc, rw, up, hw);
    chk("touch3_hit", 64'(sc), 64'd0);
    run_req(1'b1, 1'b0, 52'h4, 6'd5, 0, sc, rw, up, hw);
    chk("touch4_hit", 64'(sc), 64'd0);
    run_req(1'b1, 1'b0, 52'h5, 6'd5, 0, sc, rw, up, hw);
    chk("touch5_hit", 64'(sc), 64'd0);
    clear_ev();
    run_req(1'b1, 1'b0, 52'h6, 6'd5, 5, sc, rw, up, hw);
    chk("dirty_evict_txns", 64'(ev_kind.size()), 64'd2);
    if (ev_kind.size() == 2) begin
      chk("wb_first_kind", 64'(ev_kind[0]), 64'd1);
      chk("wb_first_tag", 64'(ev_tag[0]), 64'd1);
      chk("wb_first_index", 64'(ev_idx[0]), 64'd5);
      chk("alloc_second_kind", 64'(ev_kind[1]), 64'd2);
      chk("alloc_second_tag", 64'(ev_tag[1]), 64'd6);
    end
    chk("dirty_evict_way", 64'(rw), 64'd0);
    chk("dirty_evict_stall_cycles", 64'(sc), 64'd14);

    // Read+write together is a store; leaves dirty lines in sets 0 and 63
    run_req(1'b1, 1'b1, 52'hA, 6'd0, 0, sc, rw, up, hw);
    chk("rw_update", 64'(up), 64'd1);
    chk("rw_way", 64'(hw), 64'd0);
    run_req(1'b0, 1'b1, 52'hB, 6'd63, 0, sc, rw, up, hw);
    chk("w63_update", 64'(up), 64'd1);

    // Flush: exactly two write-backs in set order, one done pulse, no restart while flush stays high
    clear_ev();
    nd = 0;
    bus.flush = 1'b1;
    #1;
    chk("flush_accept_stall", 64'(bus.stall), 64'd1);
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      bus.ready_L2_L1 = 1'b0;
      #1;
      if (bus.flush_done) nd++;
      if (bus.read_L1_L2) begin
        ev_kind.push_back(2); ev_tag.push_back(bus.l2_tag); ev_idx.push_back(bus.l2_index);
      end
      if (bus.write_L1_L2) begin
        bus.ready_L2_L1 = 1'b1;
        ev_kind.push_back(1); ev_tag.push_back(bus.l2_tag); ev_idx.push_back(bus.l2_index);
      end
    end
    chk("flush_done_pulses", 64'(nd), 64'd1);
    chk("flush_held_no_restart", 64'(bus.stall), 64'd0);
    chk("flush_txn_count", 64'(ev_kind.size()), 64'd2);
    if (ev_kind.size() == 2) begin
      chk("flush_wb0_kind", 64'(ev_kind[0]), 64'd1);
      chk("flush_wb0_index", 64'(ev_idx[0]), 64'd0);
      chk("flush_wb0_tag", 64'(ev_tag[0]), 64'hA);
      chk("flush_wb1_kind", 64'(ev_kind[1]), 64'd1);
      chk("flush_wb1_index", 64'(ev_idx[1]), 64'd63);
      chk("flush_wb1_tag", 64'(ev_tag[1]), 64'hB);
    end
    @(negedge clk);
    bus.ready_L2_L1 = 1'b0;
    bus.flush = 1'b0;
    run_req(1'b1, 1'b0, 52'hA, 6'd0, 0, sc, rw, up, hw);
    chk("post_flush_miss_set0", 64'(sc), 64'd3);
    chk("post_flush_way_set0", 64'(rw), 64'd0);
    run_req(1'b1, 1'b0, 52'hB, 6'd63, 0, sc, rw, up, hw);
    chk("post_flush_miss_set63", 64'(sc), 64'd3);

    // Reset while ALLOCATE is waiting on L2
    bus.read_C_L1 = 1'b1; bus.tag = 52'h7; bus.index = 6'd9;
    @(negedge clk); #1;
    chk("pre_reset_alloc", 64'(bus.read_L1_L2), 64'd1);
    nrst = 1'b0;
    @(negedge clk);
    nrst = 1'b1;
    bus.read_C_L1 = 1'b0;
    #1;
    chk("reset_drops_rd_l2", 64'(bus.read_L1_L2), 64'd0);
    chk("reset_no_refill", 64'(bus.refill), 64'd0);
    chk("reset_idle_stall", 64'(bus.stall), 64'd0);
    @(negedge clk); #1;
    chk("reset_no_late_refill", 64'(bus.refill), 64'd0);
    @(negedge clk);
    run_req(1'b1, 1'b0, 52'h6, 6'd5, 0, sc, rw, up, hw);
    chk("reset_invalidates_stall", 64'(sc), 64'd3);
    chk("reset_invalidates_way", 64'(rw), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
